// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor with valid/ready on both sides.
// The carry chain is cut into STAGES chunks; each stage resolves one chunk per cycle.
module pipelined_adder #(
  parameter int WIDTH  = 48,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             ovf
);

  localparam int CW   = (WIDTH + STAGES - 1) / STAGES;
  localparam int LAST = STAGES - 1;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (STAGES - 1) * CW >= WIDTH) begin : g_param_check
    $error("pipelined_adder: unsupported WIDTH/STAGES combination");
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CW;
    localparam int HI = ((k + 1) * CW < WIDTH) ? (k + 1) * CW - 1 : WIDTH - 1;
    localparam int N  = HI - LO + 1;

    logic             v, c, m;
    logic [WIDTH-1:0] r;
    logic             rdy, nrdy;
    logic             pv, pc, pm;
    logic [WIDTH-1:0] pr, rn;
    logic [WIDTH-1:LO] pbx;
    logic [N:0]       sum;

    // Subtract is folded in at entry: b is inverted and the carry-in becomes !cin.
    if (k == 0) begin : g_head
      assign pv  = in_valid;
      assign pc  = cin ^ sub;
      assign pm  = sub;
      assign pr  = a;
      assign pbx = b ^ {WIDTH{sub}};
    end else begin : g_body
      assign pv  = g_stage[k-1].v;
      assign pc  = g_stage[k-1].c;
      assign pm  = g_stage[k-1].m;
      assign pr  = g_stage[k-1].r;
      assign pbx = g_stage[k-1].g_link.bx;
    end

    assign rdy = !v || nrdy;
    assign sum = {1'b0, pr[HI:LO]} + {1'b0, pbx[HI:LO]} + {{N{1'b0}}, pc};

    // r carries the resolved low chunks plus the still-untouched upper bits of a.
    always_comb begin
      rn        = pr;
      rn[HI:LO] = sum[N-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= 1'b0;
        c <= 1'b0;
        m <= 1'b0;
        r <= '0;
      end else if (rdy) begin
        v <= pv;
        if (pv) begin
          c <= sum[N];
          m <= pm;
          r <= rn;
        end
      end
    end

    if (k < STAGES - 1) begin : g_link
      logic [WIDTH-1:HI+1] bx;

      assign nrdy = g_stage[k+1].rdy;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bx <= '0;
        end else if (rdy && pv) begin
          bx <= pbx[WIDTH-1:HI+1];
        end
      end
    end else begin : g_tail
      logic am, bm;

      assign nrdy = out_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          am <= 1'b0;
          bm <= 1'b0;
        end else if (rdy && pv) begin
          am <= pr[WIDTH-1];
          bm <= pbx[WIDTH-1];
        end
      end
    end
  end

  assign in_ready  = g_stage[0].rdy;
  assign out_valid = g_stage[LAST].v;
  // bm is the effective (possibly inverted) b sign, so one overflow rule covers add and sub.
  assign out = {g_stage[LAST].c ^ g_stage[LAST].m, g_stage[LAST].r};
  assign ovf = (g_stage[LAST].g_tail.am == g_stage[LAST].g_tail.bm) &&
               (g_stage[LAST].r[WIDTH-1] != g_stage[LAST].g_tail.am);

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomised checks of pipelined_adder: arithmetic, latency,
// backpressure, mid-flight reset and a WIDTH/STAGES sweep against a reference model.
module tb_pipelined_adder;

  localparam int NSWEEP = 1000;

  typedef struct {
    logic [63:0] o;
    logic        v;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] a = '0;
  logic [47:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [48:0] out;
  logic        ovf;
  logic        sweep_go = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(48), .STAGES(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .ovf(ovf)
  );

  function automatic logic [63:0] ref_out(int w, logic [63:0] x, logic [63:0] y, logic c, logic s);
    logic [63:0] m1;
    m1 = (64'd1 << (w + 1)) - 64'd1;
    if (s) return (x - y - 64'(c)) & m1;
    return (x + y + 64'(c)) & m1;
  endfunction

  function automatic logic ref_ovf(int w, logic [63:0] x, logic [63:0] y, logic [63:0] o, logic s);
    logic xs, ys, os;
    xs = x[w-1];
    ys = y[w-1];
    os = o[w-1];
    return s ? (xs != ys && os != xs) : (xs == ys && os != xs);
  endfunction

  // Drives one operation into an empty pipe; lat counts edges from the accepting edge (inclusive).
  task automatic run_one(input logic [47:0] ta, input logic [47:0] tb_, input logic tc, input logic ts,
                         output logic [48:0] ro, output logic rv, output int lat);
    logic acc;
    ro  = '0;
    rv  = 1'b0;
    lat = -1;
    @(posedge clk); #1;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (acc) begin
      for (int n = 1; n <= 20; n++) begin
        if (out_valid) begin
          lat = n; ro = out; rv = ovf;
          break;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out !== '0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b out=%h ovf=%b, required 0/0/0", out_valid, out, ovf);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_add;
    logic [48:0] o; logic v; int lat;
    run_one(48'hFFFF_FFFF_FFFF, 48'd1, 1'b0, 1'b0, o, v, lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL add_latency: got %0d, required 3", lat); end
    checks++;
    if (o !== 49'h1_0000_0000_0000 || v !== 1'b0) begin
      errors++; $display("FAIL add_max: got out=%h ovf=%b, required 1000000000000/0", o, v);
    end
    run_one(48'h7FFF_FFFF_FFFF, 48'd1, 1'b0, 1'b0, o, v, lat);
    checks++;
    if (o !== 49'h0_8000_0000_0000 || v !== 1'b1) begin
      errors++; $display("FAIL add_ovf: got out=%h ovf=%b, required 0800000000000/1", o, v);
    end
  endtask

  task automatic test_cross_chunk;
    logic [48:0] o; logic v; int lat;
    run_one(48'h0000_FFFF_FFFF, 48'd0, 1'b1, 1'b0, o, v, lat);
    checks++;
    if (o !== 49'h0_0001_0000_0000 || v !== 1'b0 || lat != 3) begin
      errors++; $display("FAIL cross_chunk: got out=%h ovf=%b lat=%0d, required 0000100000000/0/3", o, v, lat);
    end
  endtask

  task automatic test_sub;
    logic [48:0] o; logic v; int lat;
    run_one(48'd5, 48'd7, 1'b0, 1'b1, o, v, lat);
    checks++;
    if (o !== 49'h1_FFFF_FFFF_FFFE || v !== 1'b0) begin
      errors++; $display("FAIL sub_neg: got out=%h ovf=%b, required 1fffffffffffe/0", o, v);
    end
    run_one(48'h8000_0000_0000, 48'd1, 1'b0, 1'b1, o, v, lat);
    checks++;
    if (o !== 49'h0_7FFF_FFFF_FFFF || v !== 1'b1) begin
      errors++; $display("FAIL sub_ovf: got out=%h ovf=%b, required 07fffffffffff/1", o, v);
    end
    run_one(48'd10, 48'd3, 1'b1, 1'b1, o, v, lat);
    checks++;
    if (o !== 49'h0_0000_0000_0006 || v !== 1'b0) begin
      errors++; $display("FAIL sub_borrow_in: got out=%h ovf=%b, required 0000000000006/0", o, v);
    end
  endtask

  task automatic test_back_to_back;
    int sent = 0, got = 0;
    logic [48:0] ex;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 6; c++) begin
      @(posedge clk); #1;
      if (sent < 6) begin
        in_valid = 1'b1; a = 48'h100 + 48'(sent); b = 48'(sent); cin = 1'b0; sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: cycle %0d in_ready=%b, required 1", c, in_ready); end
      end
      if (out_valid) begin
        ex = 49'h100 + 49'(2 * got);
        checks++;
        if (out !== ex || c != got + 3) begin
          errors++; $display("FAIL b2b_result: item %0d cycle %0d out=%h, required out=%h at cycle %0d", got, c, out, ex, got + 3);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 6) begin errors++; $display("FAIL b2b_count: got %0d results, required 6", got); end
  endtask

  task automatic test_backpressure;
    logic [47:0] va [10];
    logic [47:0] vb [10];
    logic        vc [10];
    logic        vs [10];
    logic [63:0] eo;
    logic [48:0] hold_o;
    logic        hold_v, held = 1'b0, seen_drop = 1'b0;
    int sent = 0, got = 0, extra = 0;
    for (int i = 0; i < 10; i++) begin
      va[i] = 48'({$urandom(), $urandom()});
      vb[i] = 48'({$urandom(), $urandom()});
      vc[i] = 1'($urandom_range(0, 1));
      vs[i] = 1'($urandom_range(0, 1));
    end
    for (int c = 0; c < 60 && got < 10; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 2 && c <= 7);
      if (sent < 10) begin
        in_valid = 1'b1; a = va[sent]; b = vb[sent]; cin = vc[sent]; sub = vs[sent];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (!in_ready && !seen_drop) begin
        seen_drop = 1'b1;
        checks++;
        if (sent != 3) begin errors++; $display("FAIL bp_fill: in_ready fell after %0d accepts, required 3", sent); end
      end
      if (c == 8) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: in_ready=%b when out_ready rose, required 1", in_ready); end
      end
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out !== hold_o || ovf !== hold_v) begin
          errors++; $display("FAIL bp_stable: out_valid=%b out=%h ovf=%b, required 1/%h/%b", out_valid, out, ovf, hold_o, hold_v);
        end
      end
      held = out_valid && !out_ready;
      hold_o = out;
      hold_v = ovf;
      if (out_valid && out_ready) begin
        eo = ref_out(48, 64'(va[got]), 64'(vb[got]), vc[got], vs[got]);
        checks++;
        if (out !== eo[48:0] || ovf !== ref_ovf(48, 64'(va[got]), 64'(vb[got]), eo, vs[got])) begin
          errors++; $display("FAIL bp_result: item %0d out=%h ovf=%b, required %h/%b", got, out, ovf, eo[48:0],
                             ref_ovf(48, 64'(va[got]), 64'(vb[got]), eo, vs[got]));
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    checks++;
    if (got != 10 || extra != 0 || !seen_drop) begin
      errors++; $display("FAIL bp_count: got %0d results, %0d extra, drop seen %b, required 10/0/1", got, extra, seen_drop);
    end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    logic seen = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; a = 48'h11; b = 48'h22; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    a = 48'h33; b = 48'h44;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== '0 || ovf !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: out_valid=%b out=%h ovf=%b, required 0/0/0", out_valid, out, ovf);
    end
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    a = 48'h1234; b = 48'h1000; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (n == 3) begin
        checks++;
        if (out_valid !== 1'b1 || out !== 49'h2234) begin
          errors++; $display("FAIL rst_mid_new: out_valid=%b out=%h, required 1/0000000002234", out_valid, out);
        end
        seen = 1'b1;
      end else if (out_valid !== 1'b0) begin
        bad++;
      end
    end
    checks++;
    if (bad != 0 || !seen) begin errors++; $display("FAIL rst_mid_stale: %0d unexpected valid cycles, required 0", bad); end
  endtask

  task automatic test_param_sweep;
    int n = 0;
    sweep_go = 1'b1;
    while (!(sw[0].done && sw[1].done && sw[2].done && sw[3].done) && n < 40000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 40000) begin errors++; $display("FAIL sweep_timeout: %0d cycles elapsed, required completion", n); end
  endtask

  for (genvar i = 0; i < 4; i++) begin : sw
    localparam int W = (i == 0) ? 8 : (i == 1) ? 32 : (i == 2) ? 49 : 48;
    localparam int S = (i == 0) ? 1 : (i == 1) ? 4 : (i == 2) ? 5 : 48;

    logic         iv = 1'b0, icin = 1'b0, isub = 1'b0, oor = 1'b0, done = 1'b0;
    logic         ir, ov, oovf;
    logic [W-1:0] ia = '0, ib = '0;
    logic [W:0]   oo;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
      .a(ia), .b(ib), .cin(icin), .sub(isub),
      .out_valid(ov), .out_ready(oor), .out(oo), .ovf(oovf)
    );

    initial begin : drive
      exp_t        q[$];
      exp_t        e;
      logic [63:0] r1, r2, eo;
      int          sent, it, last_stall, lat;
      sent = 0; it = 0; last_stall = -1;
      wait (sweep_go);
      while ((sent < NSWEEP || q.size() != 0) && it < 30000) begin
        @(posedge clk); #1;
        r1 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        iv   = (sent < NSWEEP) && ($urandom_range(0, 3) != 0);
        ia   = r1[W-1:0];
        ib   = r2[W-1:0];
        icin = 1'($urandom_range(0, 1));
        isub = 1'($urandom_range(0, 1));
        oor  = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (!oor) last_stall = it;
        if (ov && oor) begin
          checks++;
          if (q.size() == 0) begin
            errors++; $display("FAIL sweep_spurious W=%0d S=%0d: out=%h with nothing pending, required no output", W, S, oo);
          end else begin
            e = q.pop_front();
            lat = it - e.acc;
            if (oo !== e.o[W:0] || oovf !== e.v) begin
              errors++; $display("FAIL sweep_result W=%0d S=%0d: out=%h ovf=%b, required %h/%b", W, S, oo, oovf, e.o[W:0], e.v);
            end
            checks++;
            if ((last_stall <= e.acc) ? (lat != S) : (lat < S)) begin
              errors++; $display("FAIL sweep_latency W=%0d S=%0d: latency %0d, required %0d (stalled %b)", W, S, lat, S, last_stall > e.acc);
            end
          end
        end
        if (iv && ir) begin
          eo = ref_out(W, 64'(ia), 64'(ib), icin, isub);
          q.push_back('{o: eo, v: ref_ovf(W, 64'(ia), 64'(ib), eo, isub), acc: it});
          sent++;
        end
        it++;
      end
      iv = 1'b0;
      checks++;
      if (sent != NSWEEP || q.size() != 0) begin
        errors++; $display("FAIL sweep_count W=%0d S=%0d: sent %0d pending %0d, required %0d/0", W, S, sent, q.size(), NSWEEP);
      end
      done = 1'b1;
    end
  end

  initial begin
    test_reset;
    test_add;
    test_cross_chunk;
    test_sub;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_param_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
